// File: rtl/mem_access_pkg.sv
// Shared size codes, FSM state encoding and the alignment rule for the data-memory access unit.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Size code 2'b11 is illegal and is reported through the same misalign path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-bus signals of the data-memory access unit.
// slave = the access unit itself; master = control FSM plus memory bus model.
interface mem_access_ctrl_if;

    logic        start;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        misalign;
    logic        bus_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport slave (
        input  start, mem_write, size, load_signed, addr, wdata, bus_rdata, bus_ack,
        output mem_data_out, busy, done, misalign, bus_timeout,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output start, mem_write, size, load_signed, addr, wdata, bus_rdata, bus_ack,
        input  mem_data_out, busy, done, misalign, bus_timeout,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it to 32 bits.
// Latency: combinational.
// Backpressure: none.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_result = i_rdata;
        case (i_size)
            SZ_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access unit: latches a load/store, runs one req/ack bus cycle, formats load data.
// Latency: done 2 cycles after start for a first-cycle ack; misaligned requests finish next cycle.
// Backpressure: bus_req held until bus_ack or TIMEOUT cycles; start ignored while not idle.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave mif
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_mem_write;
    logic        r_signed;
    logic        r_misalign;
    logic        r_timeout;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_data;
    logic [7:0]  r_cnt;

    logic        w_bad_req;
    logic        w_ack_hit;
    logic        w_cnt_expired;
    logic        w_in_req;
    logic        w_in_done;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_load_data;

    assign w_bad_req = is_misaligned(mif.size, mif.addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An ack on the last allowed cycle wins over the timeout.
    always_comb begin
        w_next_state  = r_state;
        w_ack_hit     = 1'b0;
        w_cnt_expired = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mif.start) begin
                    w_next_state = w_bad_req ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mif.bus_ack) begin
                    w_ack_hit    = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_expired = 1'b1;
                    w_next_state  = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_write <= 1'b0;
            r_signed    <= 1'b0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_data  <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_state == S_IDLE && mif.start) begin
                r_mem_write <= mif.mem_write;
                r_signed    <= mif.load_signed;
                r_size      <= mif.size;
                r_addr      <= mif.addr;
                r_wdata     <= mif.wdata;
                r_misalign  <= w_bad_req;
                r_timeout   <= 1'b0;
                r_cnt       <= '0;
            end
            if (r_state == S_REQ) begin
                r_cnt     <= r_cnt + 8'd1;
                r_timeout <= w_cnt_expired;
                if (w_ack_hit && !r_mem_write) begin
                    r_mem_data <= w_load_data;
                end
            end
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_lanes = r_wdata;
        case (r_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = r_wdata;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata   (mif.bus_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_result  (w_load_data)
    );

    // Bus outputs are decoded from state so an async reset drops them without waiting for an edge.
    assign w_in_req  = (r_state == S_REQ);
    assign w_in_done = (r_state == S_DONE);

    assign mif.busy         = w_in_req;
    assign mif.bus_req      = w_in_req;
    assign mif.done         = w_in_done;
    assign mif.misalign     = w_in_done & r_misalign;
    assign mif.bus_timeout  = w_in_done & r_timeout;
    assign mif.bus_we       = w_in_req & r_mem_write;
    assign mif.bus_addr     = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mif.bus_be       = w_in_req ? w_be : 4'b0000;
    assign mif.bus_wdata    = (w_in_req && r_mem_write) ? w_lanes : 32'h0;
    assign mif.mem_data_out = r_mem_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: transaction-level expected waveform checked every cycle, plus literal pins.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if mif();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Expected outputs for the current cycle
    logic        e_busy, e_done, e_misalign, e_timeout, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_mem_data;
    logic [3:0]  e_be;

    // DUT observations captured during the last transaction
    int          cap_lat, cap_req;
    logic        cap_mis, cap_tmo, cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || ((int'(a[1:0]) % m_nbytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int off;
        int nb;
        nb  = m_nbytes(sz);
        off = int'(a[1:0]);
        be  = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = m_nbytes(sz);
        r  = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int nb;
        nb   = m_nbytes(sz);
        v    = rd >> (8 * int'(a[1:0]));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sgn && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_misalign = 0; e_timeout = 0; e_req = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_be = '0;
    endtask

    task automatic set_req(input bit mw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        e_busy  = 1; e_req = 1; e_we = mw;
        e_addr  = a & 32'hFFFF_FFFC;
        e_be    = m_be(sz, a);
        e_wdata = mw ? m_wdata(sz, wd) : 32'h0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",         32'(mif.busy),        32'(e_busy));
            check("done",         32'(mif.done),        32'(e_done));
            check("misalign",     32'(mif.misalign),    32'(e_misalign));
            check("bus_timeout",  32'(mif.bus_timeout), 32'(e_timeout));
            check("bus_req",      32'(mif.bus_req),     32'(e_req));
            check("bus_we",       32'(mif.bus_we),      32'(e_we));
            check("bus_addr",     mif.bus_addr,         e_addr);
            check("bus_be",       32'(mif.bus_be),      32'(e_be));
            check("bus_wdata",    mif.bus_wdata,        e_wdata);
            check("mem_data_out", mif.mem_data_out,     e_mem_data);
        end
    end

    // ack_at: REQ cycle (1-based) carrying bus_ack; 0 = never acknowledge
    task automatic xact(input bit mw, input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        bit ms;
        int done_c;
        ms     = m_misaligned(sz, a);
        done_c = ms ? 1 : ((ack_at > 0) ? ack_at + 1 : TO + 1);
        cap_lat = -1; cap_req = 0; cap_mis = 0; cap_tmo = 0; cap_we = 0;
        cap_be = '0; cap_addr = '0; cap_wdata = '0;
        mif.start = 1'b1; mif.mem_write = mw; mif.size = sz; mif.load_signed = sgn;
        mif.addr = a; mif.wdata = wd; mif.bus_ack = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            set_idle();
            if (c < done_c) begin
                set_req(mw, sz, a, wd);
            end else if (c == done_c) begin
                e_done     = 1;
                e_misalign = ms;
                e_timeout  = !ms && (ack_at == 0);
                if (!ms && ack_at != 0 && !mw) e_mem_data = m_load(sz, sgn, a, rd);
            end
            // Request-side noise outside IDLE must be ignored
            mif.start       = (c <= done_c) ? 1'($urandom) : 1'b0;
            mif.addr        = $urandom;
            mif.size        = 2'($urandom);
            mif.wdata       = $urandom;
            mif.mem_write   = 1'($urandom);
            mif.load_signed = 1'($urandom);
            mif.bus_ack     = (c < done_c) ? (c == ack_at) : 1'($urandom);
            mif.bus_rdata   = (c == ack_at) ? rd : $urandom;
            if (mif.bus_req) begin
                cap_req++;
                cap_be = mif.bus_be; cap_addr = mif.bus_addr; cap_wdata = mif.bus_wdata; cap_we = mif.bus_we;
            end
            if (mif.done && cap_lat < 0) begin
                cap_lat = c; cap_mis = mif.misalign; cap_tmo = mif.bus_timeout;
            end
        end
        mif.start = 1'b0;
        mif.bus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mif.start = 0; mif.mem_write = 0; mif.size = '0; mif.load_signed = 0;
        mif.addr = '0; mif.wdata = '0; mif.bus_rdata = '0; mif.bus_ack = 0;
        set_idle();
        e_mem_data = '0;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_data", mif.mem_data_out, 32'h0);
        check("rst_bus_req",  32'(mif.bus_req), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        xact(0, SZ_WORD, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        check("word_lat",  32'(cap_lat), 32'd4);
        check("word_data", mif.mem_data_out, 32'hDEADBEEF);

        xact(0, SZ_BYTE, 1, 32'h103, 32'h0, 32'h80FF0011, 1);
        check("byte_s_data", mif.mem_data_out, 32'hFFFFFF80);
        check("byte_s_be",   32'(cap_be), 32'h8);
        check("byte_s_lat",  32'(cap_lat), 32'd2);

        xact(0, SZ_BYTE, 0, 32'h103, 32'h0, 32'h80FF0011, 2);
        check("byte_u_data", mif.mem_data_out, 32'h00000080);

        xact(1, SZ_HALF, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 2);
        check("hst_addr",  cap_addr, 32'h200);
        check("hst_be",    32'(cap_be), 32'hC);
        check("hst_wdata", cap_wdata, 32'hABCDABCD);
        check("hst_we",    32'(cap_we), 32'h1);
        check("hst_keep",  mif.mem_data_out, 32'h00000080);

        xact(0, SZ_WORD, 0, 32'h101, 32'h0, 32'h0, 0);
        check("mis_word_flag", 32'(cap_mis), 32'h1);
        check("mis_word_req",  32'(cap_req), 32'h0);
        check("mis_word_lat",  32'(cap_lat), 32'd1);

        xact(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0);
        check("mis_sz11_flag", 32'(cap_mis), 32'h1);
        check("mis_sz11_req",  32'(cap_req), 32'h0);

        xact(0, SZ_WORD, 0, 32'h300, 32'h0, 32'h55555555, 0);
        check("tmo_req_cycles", 32'(cap_req), 32'd8);
        check("tmo_flag",       32'(cap_tmo), 32'h1);
        check("tmo_lat",        32'(cap_lat), 32'd9);
        check("tmo_keep",       mif.mem_data_out, 32'h00000080);

        xact(0, SZ_WORD, 0, 32'h304, 32'h0, 32'hCAFEF00D, TO);
        check("lastack_tmo",  32'(cap_tmo), 32'h0);
        check("lastack_data", mif.mem_data_out, 32'hCAFEF00D);

        xact(0, SZ_HALF, 1, 32'h106, 32'h0, 32'h80017FFF, 1);
        check("half_s_hi", mif.mem_data_out, 32'hFFFF8001);
        xact(0, SZ_HALF, 1, 32'h104, 32'h0, 32'h80017FFF, 1);
        check("half_s_lo", mif.mem_data_out, 32'h00007FFF);

        xact(1, SZ_BYTE, 0, 32'h001, 32'hFFFFFFA5, 32'h0, 1);
        check("bst_wdata", cap_wdata, 32'hA5A5A5A5);
        check("bst_be",    32'(cap_be), 32'h2);
        xact(1, SZ_WORD, 0, 32'h008, 32'h01234567, 32'h0, 1);
        check("wst_wdata", cap_wdata, 32'h01234567);
        check("wst_be",    32'(cap_be), 32'hF);

        // Reset in the middle of a bus cycle
        mif.start = 1; mif.mem_write = 0; mif.size = SZ_WORD; mif.load_signed = 0;
        mif.addr = 32'h400; mif.bus_ack = 0;
        @(posedge clk); #1;
        mif.start = 0;
        set_idle();
        set_req(0, SZ_WORD, 32'h400, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle();
        e_mem_data = '0;
        #1;
        check("rstmid_req",  32'(mif.bus_req), 32'h0);
        check("rstmid_busy", 32'(mif.busy), 32'h0);
        check("rstmid_data", mif.mem_data_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        xact(0, SZ_HALF, 0, 32'h002, 32'h0, 32'h1234F00D, 1);
        check("post_rst_data", mif.mem_data_out, 32'h00001234);
        check("post_rst_lat",  32'(cap_lat), 32'd2);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
